// File: rtl/din_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : din_seq_pkg
//  Description : Shared types and constants for the DIN trigger sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package din_seq_pkg;

  // Width of the shared down-counter; large enough for a 1,000,000-cycle gap
  localparam int CNT_W = 21;

  // Number of cycles the dump request is held high
  localparam int DUMP_WIDTH = 2;

  // Sequencer states; the encodings are exported on state_dbg
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_RUN       = 3'd3,
    ST_GAP       = 3'd4,
    ST_ABORT     = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Synchronizes and debounces one active-low push button.
//                Emits a one-cycle press pulse on the accepted 1->0 change.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
  parameter int CYCLES = 50000
) (
  input  logic clk_in,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer; the raw button is asynchronous to clk_in
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], key_n};
    end
  end

  // Accept a new level only after it differs from the current one for CYCLES samples
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      level <= 1'b1;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        level <= sync[1];
        press <= ~sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/din_trig_seq.sv
`default_nettype none
// ============================================================================
//  Module      : din_trig_seq
//  Description : Turns debounced start/abort buttons into trig/dump requests
//                for the DIN serializer, tracks serializer busy, counts
//                frames, re-triggers in repeat mode and aborts on timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module din_trig_seq
  import din_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TRIG_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int GAP_CYCLES      = 1000000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       key_start_n,
  input  logic       key_abort_n,
  input  logic       repeat_en,
  input  logic       busy,
  output logic       trig,
  output logic       dump,
  output logic [7:0] frame_cnt,
  output logic       err,
  output logic [2:0] state_dbg
);

  // Counter reload values. GAP loads the full count so that trig re-rises
  // GAP_CYCLES+1 cycles after GAP entry.
  localparam logic [CNT_W-1:0] TRIG_LOAD = CNT_W'(TRIG_WIDTH - 1);
  localparam logic [CNT_W-1:0] TMO_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES);
  localparam logic [1:0]       DUMP_LOAD = 2'(DUMP_WIDTH - 1);

  logic start_ev;
  logic abort_ev;
  logic start_level;
  logic abort_level;
  logic unused_key_levels;

  logic busy_m;
  logic busy_s;
  logic busy_d;
  logic rise_q;
  logic fall_q;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       dump_cnt;
  logic             rep_q;

  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clk_in (clk_in),
    .rst    (rst),
    .key_n  (key_start_n),
    .level  (start_level),
    .press  (start_ev)
  );

  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_abort_db (
    .clk_in (clk_in),
    .rst    (rst),
    .key_n  (key_abort_n),
    .level  (abort_level),
    .press  (abort_ev)
  );

  // Debounced levels are not needed here; only the press events drive the FSM
  assign unused_key_levels = start_level ^ abort_level;

  assign state_dbg = state;

  // Synchronize busy and register its edges (busy edge to FSM action = 3 cycles)
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      busy_m <= 1'b0;
      busy_s <= 1'b0;
      busy_d <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      busy_m <= busy;
      busy_s <= busy_m;
      busy_d <= busy_s;
      rise_q <= busy_s & ~busy_d;
      fall_q <= ~busy_s & busy_d;
    end
  end

  // Sequencer FSM with shared down-counter, frame counter and sticky error
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      dump_cnt  <= '0;
      trig      <= 1'b0;
      dump      <= 1'b0;
      frame_cnt <= 8'd0;
      err       <= 1'b0;
      rep_q     <= 1'b0;
    end else if (abort_ev && (state != ST_IDLE)) begin
      // User abort outranks everything except IDLE, where it is ignored
      state    <= ST_ABORT;
      trig     <= 1'b0;
      dump     <= 1'b1;
      dump_cnt <= DUMP_LOAD;
    end else begin
      case (state)
        ST_IDLE: begin
          // An abort in the same cycle cancels the start
          if (start_ev && !abort_ev) begin
            state     <= ST_TRIG;
            cnt       <= TRIG_LOAD;
            trig      <= 1'b1;
            rep_q     <= repeat_en;
            err       <= 1'b0;
            frame_cnt <= 8'd0;
          end
        end

        ST_TRIG: begin
          if (cnt == '0) begin
            state <= ST_WAIT_BUSY;
            cnt   <= TMO_LOAD;
            trig  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_WAIT_BUSY: begin
          if (rise_q) begin
            state <= ST_RUN;
            cnt   <= TMO_LOAD;
          end else if (cnt == '0) begin
            state    <= ST_ABORT;
            err      <= 1'b1;
            dump     <= 1'b1;
            dump_cnt <= DUMP_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_RUN: begin
          if (fall_q) begin
            frame_cnt <= frame_cnt + 8'd1;
            if (rep_q) begin
              state <= ST_GAP;
              cnt   <= GAP_LOAD;
            end else begin
              state <= ST_IDLE;
            end
          end else if (cnt == '0) begin
            state    <= ST_ABORT;
            err      <= 1'b1;
            dump     <= 1'b1;
            dump_cnt <= DUMP_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_GAP: begin
          if (cnt == '0) begin
            state <= ST_TRIG;
            cnt   <= TRIG_LOAD;
            trig  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_ABORT: begin
          if (dump_cnt == 2'd0) begin
            state <= ST_IDLE;
            dump  <= 1'b0;
          end else begin
            dump_cnt <= dump_cnt - 2'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
          trig  <= 1'b0;
          dump  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_din_trig_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_din_trig_seq
//  Description : Directed self-checking bench for din_trig_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_din_trig_seq;

  localparam int DEB  = 4;
  localparam int TW   = 4;
  localparam int TMO  = 16;
  localparam int GAP  = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_ABORT = 3'd5;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       key_start_n;
  logic       key_abort_n;
  logic       repeat_en;
  logic       busy;
  logic       trig;
  logic       dump;
  logic [7:0] frame_cnt;
  logic       err;
  logic [2:0] state_dbg;

  int vectors     = 0;
  int miscompares = 0;

  // 0: busy 2 cycles after trig falls, for 10 cycles; 1: never; 2: stuck high
  int busy_mode = 0;

  // Observation counters, written only by the monitor
  int         trig_rises = 0;
  int         trig_hi    = 0;
  int         dump_hi    = 0;
  int         overlap    = 0;
  int         cyc        = 0;
  int         wb_t       = 0;
  int         run_t      = 0;
  int         gap_t      = -1;
  int         err_delta  = -1;
  int         gap_deltas[$];
  logic       trig_q = 1'b0;
  logic       err_q  = 1'b0;
  logic [2:0] st_q   = 3'd0;

  din_trig_seq #(
    .DEBOUNCE_CYCLES (DEB),
    .TRIG_WIDTH      (TW),
    .TIMEOUT_CYCLES  (TMO),
    .GAP_CYCLES      (GAP)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .key_start_n (key_start_n),
    .key_abort_n (key_abort_n),
    .repeat_en   (repeat_en),
    .busy        (busy),
    .trig        (trig),
    .dump        (dump),
    .frame_cnt   (frame_cnt),
    .err         (err),
    .state_dbg   (state_dbg)
  );

  always #5 clk_in = ~clk_in;

  // Monitor: samples on the falling edge
  initial begin
    forever begin
      @(negedge clk_in);
      cyc++;
      if (trig) trig_hi++;
      if (dump) dump_hi++;
      if (trig && dump) overlap++;
      if (trig && !trig_q) begin
        trig_rises++;
        if (gap_t >= 0) begin
          gap_deltas.push_back(cyc - gap_t);
          gap_t = -1;
        end
      end
      if (state_dbg == S_WAIT && st_q != S_WAIT) wb_t  = cyc;
      if (state_dbg == S_RUN  && st_q != S_RUN)  run_t = cyc;
      if (state_dbg == S_GAP  && st_q != S_GAP)  gap_t = cyc;
      if (state_dbg != S_GAP && state_dbg != 3'd1) gap_t = -1;
      if (err && !err_q) err_delta = cyc - ((st_q == S_WAIT) ? wb_t : run_t);
      trig_q = trig;
      err_q  = err;
      st_q   = state_dbg;
    end
  end

  // Serializer busy model
  initial begin
    logic tq_m;
    tq_m = 1'b0;
    busy = 1'b0;
    forever begin
      @(negedge clk_in);
      if (tq_m && !trig) begin
        if (busy_mode == 0) begin
          repeat (2) @(negedge clk_in);
          busy = 1'b1;
          repeat (10) @(negedge clk_in);
          busy = 1'b0;
        end else if (busy_mode == 2) begin
          repeat (2) @(negedge clk_in);
          busy = 1'b1;
          for (int k = 0; k < 200 && state_dbg != S_IDLE; k++) @(negedge clk_in);
          busy = 1'b0;
        end
      end
      tq_m = trig;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic press_start(input int bounces);
    for (int i = 0; i < bounces; i++) begin
      key_start_n = 1'b0; tick(1);
      key_start_n = 1'b1; tick(1);
    end
    key_start_n = 1'b0; tick(10);
    key_start_n = 1'b1; tick(10);
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, output bit ok);
    int n;
    n = 0;
    while (state_dbg !== s && n < max) begin tick(1); n++; end
    ok = (state_dbg === s);
  endtask

  task automatic wait_frame(input logic [7:0] v, input int max, output bit ok);
    int n;
    n = 0;
    while (frame_cnt !== v && n < max) begin tick(1); n++; end
    ok = (frame_cnt === v);
  endtask

  task automatic test_reset();
    rst = 1'b1; key_start_n = 1'b1; key_abort_n = 1'b1; repeat_en = 1'b0;
    tick(3);
    vectors++; if (trig !== 1'b0) begin miscompares++; $display("FAIL reset_trig: got %b want 0", trig); end
    vectors++; if (dump !== 1'b0) begin miscompares++; $display("FAIL reset_dump: got %b want 0", dump); end
    vectors++; if (frame_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    vectors++; if (state_dbg !== S_IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    rst = 1'b0;
    tick(5);
    vectors++; if (state_dbg !== S_IDLE) begin miscompares++; $display("FAIL reset_release_state: got %0d want 0", state_dbg); end
  endtask

  task automatic test_single_shot();
    int r0, h0, d0, n;
    bit ok;
    r0 = trig_rises; h0 = trig_hi; d0 = dump_hi;
    busy_mode = 0; repeat_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      key_start_n = 1'b0; tick(1);
      key_start_n = 1'b1; tick(1);
    end
    key_start_n = 1'b0;
    n = 0;
    while (trig !== 1'b1 && n < 20) begin tick(1); n++; end
    // Key is driven half a cycle before the first rising edge samples it
    vectors++; if (n - 1 != DEB + 2) begin miscompares++; $display("FAIL ss_latency: got %0d want %0d", n - 1, DEB + 2); end
    tick(5);
    key_start_n = 1'b1;
    wait_state(S_IDLE, 100, ok);
    tick(10);
    vectors++; if (!ok) begin miscompares++; $display("FAIL ss_idle_timeout: got state %0d want 0", state_dbg); end
    vectors++; if (trig_rises - r0 != 1) begin miscompares++; $display("FAIL ss_trig_count: got %0d want 1", trig_rises - r0); end
    vectors++; if (trig_hi - h0 != TW) begin miscompares++; $display("FAIL ss_trig_width: got %0d want %0d", trig_hi - h0, TW); end
    vectors++; if (frame_cnt !== 8'd1) begin miscompares++; $display("FAIL ss_frame_cnt: got %0d want 1", frame_cnt); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL ss_err: got %b want 0", err); end
    vectors++; if (dump_hi - d0 != 0) begin miscompares++; $display("FAIL ss_no_dump: got %0d want 0", dump_hi - d0); end
  endtask

  task automatic test_repeat();
    int r0, d0, g0;
    bit ok;
    r0 = trig_rises; d0 = dump_hi; g0 = gap_deltas.size();
    busy_mode = 0; repeat_en = 1'b1;
    press_start(0);
    repeat_en = 1'b0;   // only the value at the press matters
    wait_frame(8'd5, 1000, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rep_reach5: got %0d want 5", frame_cnt); end
    key_abort_n = 1'b0; tick(10); key_abort_n = 1'b1;
    wait_state(S_IDLE, 50, ok);
    tick(10);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rep_idle_timeout: got state %0d want 0", state_dbg); end
    vectors++; if (frame_cnt !== 8'd5) begin miscompares++; $display("FAIL rep_frame_cnt: got %0d want 5", frame_cnt); end
    vectors++; if (dump_hi - d0 != 2) begin miscompares++; $display("FAIL rep_dump_width: got %0d want 2", dump_hi - d0); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rep_err: got %b want 0", err); end
    vectors++; if (trig_rises - r0 != 5) begin miscompares++; $display("FAIL rep_trig_count: got %0d want 5", trig_rises - r0); end
    vectors++; if (gap_deltas.size() - g0 != 4) begin miscompares++; $display("FAIL rep_gap_count: got %0d want 4", gap_deltas.size() - g0); end
    for (int i = g0; i < gap_deltas.size(); i++) begin
      vectors++;
      if (gap_deltas[i] != GAP + 1) begin miscompares++; $display("FAIL rep_gap_delay[%0d]: got %0d want %0d", i - g0, gap_deltas[i], GAP + 1); end
    end
  endtask

  task automatic test_timeout_wait();
    int r0, d0;
    bit ok;
    r0 = trig_rises; d0 = dump_hi;
    busy_mode = 1; repeat_en = 1'b0;
    press_start(0);
    wait_state(S_IDLE, 100, ok);
    tick(5);
    vectors++; if (!ok) begin miscompares++; $display("FAIL tw_idle_timeout: got state %0d want 0", state_dbg); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL tw_err: got %b want 1", err); end
    vectors++; if (err_delta != TMO) begin miscompares++; $display("FAIL tw_err_delay: got %0d want %0d", err_delta, TMO); end
    vectors++; if (dump_hi - d0 != 2) begin miscompares++; $display("FAIL tw_dump_width: got %0d want 2", dump_hi - d0); end
    vectors++; if (trig_rises - r0 != 1) begin miscompares++; $display("FAIL tw_trig_count: got %0d want 1", trig_rises - r0); end
    busy_mode = 0;
    press_start(0);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL tw_err_cleared: got %b want 0", err); end
    wait_state(S_IDLE, 100, ok);
    tick(10);
    vectors++; if (frame_cnt !== 8'd1) begin miscompares++; $display("FAIL tw_next_frame: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_timeout_run();
    int d0;
    bit ok;
    d0 = dump_hi;
    busy_mode = 0; repeat_en = 1'b1;
    press_start(0);
    repeat_en = 1'b0;
    wait_frame(8'd1, 200, ok);
    busy_mode = 2;   // the next frame's busy never drops
    vectors++; if (!ok) begin miscompares++; $display("FAIL tr_first_frame: got %0d want 1", frame_cnt); end
    wait_state(S_ABORT, 200, ok);
    wait_state(S_IDLE, 50, ok);
    tick(10);
    vectors++; if (!ok) begin miscompares++; $display("FAIL tr_idle_timeout: got state %0d want 0", state_dbg); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL tr_err: got %b want 1", err); end
    vectors++; if (err_delta != TMO) begin miscompares++; $display("FAIL tr_err_delay: got %0d want %0d", err_delta, TMO); end
    vectors++; if (dump_hi - d0 != 2) begin miscompares++; $display("FAIL tr_dump_width: got %0d want 2", dump_hi - d0); end
    vectors++; if (frame_cnt !== 8'd1) begin miscompares++; $display("FAIL tr_frame_cnt: got %0d want 1", frame_cnt); end
    busy_mode = 0;
    tick(10);
  endtask

  task automatic test_wrap_collision();
    int r0, d0, n;
    bit ok;
    busy_mode = 0; repeat_en = 1'b1;
    press_start(0);
    repeat_en = 1'b0;
    wait_frame(8'd255, 20000, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL wc_reach255: got %0d want 255", frame_cnt); end
    n = 0;
    while (frame_cnt === 8'd255 && n < 100) begin tick(1); n++; end
    vectors++; if (frame_cnt !== 8'd0) begin miscompares++; $display("FAIL wc_wrap: got %0d want 0", frame_cnt); end
    wait_state(S_RUN, 100, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL wc_run_timeout: got state %0d want 3", state_dbg); end
    r0 = trig_rises; d0 = dump_hi;
    key_start_n = 1'b0; key_abort_n = 1'b0;
    tick(10);
    key_start_n = 1'b1; key_abort_n = 1'b1;
    wait_state(S_IDLE, 50, ok);
    tick(10);
    vectors++; if (!ok) begin miscompares++; $display("FAIL wc_idle_timeout: got state %0d want 0", state_dbg); end
    vectors++; if (dump_hi - d0 != 2) begin miscompares++; $display("FAIL wc_dump_width: got %0d want 2", dump_hi - d0); end
    vectors++; if (trig_rises - r0 != 0) begin miscompares++; $display("FAIL wc_no_trig: got %0d want 0", trig_rises - r0); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL wc_err: got %b want 0", err); end
    vectors++; if (frame_cnt !== 8'd0) begin miscompares++; $display("FAIL wc_frame_cnt: got %0d want 0", frame_cnt); end
    tick(20);
  endtask

  task automatic test_reset_mid();
    int d0, r0, n;
    busy_mode = 1; repeat_en = 1'b0;
    key_start_n = 1'b0;
    n = 0;
    while (trig !== 1'b1 && n < 20) begin tick(1); n++; end
    vectors++; if (trig !== 1'b1) begin miscompares++; $display("FAIL rm_trig_seen: got %b want 1", trig); end
    d0 = dump_hi; r0 = trig_rises;
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (trig !== 1'b0) begin miscompares++; $display("FAIL rm_trig: got %b want 0", trig); end
    vectors++; if (state_dbg !== S_IDLE) begin miscompares++; $display("FAIL rm_state: got %0d want 0", state_dbg); end
    vectors++; if (dump !== 1'b0) begin miscompares++; $display("FAIL rm_dump: got %b want 0", dump); end
    vectors++; if (frame_cnt !== 8'd0) begin miscompares++; $display("FAIL rm_frame_cnt: got %0d want 0", frame_cnt); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rm_err: got %b want 0", err); end
    key_start_n = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(15);
    vectors++; if (dump_hi - d0 != 0) begin miscompares++; $display("FAIL rm_no_dump: got %0d want 0", dump_hi - d0); end
    vectors++; if (trig_rises - r0 != 0) begin miscompares++; $display("FAIL rm_no_retrig: got %0d want 0", trig_rises - r0); end
    vectors++; if (state_dbg !== S_IDLE) begin miscompares++; $display("FAIL rm_state_after: got %0d want 0", state_dbg); end
  endtask

  task automatic test_exclusive();
    vectors++; if (overlap != 0) begin miscompares++; $display("FAIL trig_dump_overlap: got %0d want 0", overlap); end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_repeat();
    test_timeout_wait();
    test_timeout_run();
    test_wrap_collision();
    test_reset_mid();
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
